// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: control-FSM encodings, default timing parameters and
// the digit-counter moduli used by the downstream counter chain.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } sw_state_t;

    // 10 ms debounce and 100 Hz count tick at a 50 MHz system clock.
    localparam int unsigned DEB_CYCLES_DEF = 500000;
    localparam int unsigned TICK_DIV_DEF   = 500000;

    // Moduli of the digit chain, least-significant first (cc.ss.mm display).
    localparam int unsigned DIG_MOD_CSEC_UNITS = 10;
    localparam int unsigned DIG_MOD_CSEC_TENS  = 10;
    localparam int unsigned DIG_MOD_SEC_UNITS  = 10;
    localparam int unsigned DIG_MOD_SEC_TENS   = 6;
    localparam int unsigned DIG_MOD_MIN_UNITS  = 10;
    localparam int unsigned DIG_MOD_MIN_TENS   = 6;

    // Width of a counter that runs 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_cond.sv
// Push-button conditioner: two-flop synchroniser, stability debounce and a one-cycle
// pulse on each accepted press (accepted 0->1 change of the level).
module btn_cond
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int unsigned CW = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    // The counter only advances while the synchronised input disagrees with the
    // accepted level; any return to agreement discards the partial interval.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_press <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-end: conditions start/stop/clear buttons, runs the IDLE/RUN/PAUSE
// machine and produces the count-enable tick and clear pulse for the digit chain.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int unsigned TICK_DIV   = TICK_DIV_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_clear,
    output logic       run,
    output logic       tick,
    output logic       clr,
    output logic [1:0] state
);

    localparam int unsigned PW = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic w_press_start;
    logic w_press_stop;
    logic w_press_clear;
    logic w_level_start;
    logic w_level_stop;
    logic w_level_clear;
    logic [2:0] w_unused_levels;

    sw_state_t     r_state;
    logic          r_run;
    logic          r_tick;
    logic          r_clr;
    logic [PW-1:0] r_presc;

    btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn_start (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_start),
        .level (w_level_start),
        .press (w_press_start)
    );

    btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn_stop (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_stop),
        .level (w_level_stop),
        .press (w_press_stop)
    );

    btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn_clear (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_clear),
        .level (w_level_clear),
        .press (w_press_clear)
    );

    // Only the press pulses drive control; the accepted levels are not needed here.
    assign w_unused_levels = {w_level_start, w_level_stop, w_level_clear};

    // The prescaler step is decided by the current state, so a wrap in the last RUN
    // cycle still produces its tick even when the same edge leaves RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_run   <= 1'b0;
            r_tick  <= 1'b0;
            r_clr   <= 1'b0;
            r_presc <= '0;
        end else begin
            r_clr  <= w_press_clear;
            r_tick <= 1'b0;

            case (r_state)
                ST_RUN: begin
                    if (r_presc == PRESC_LAST) begin
                        r_presc <= '0;
                        r_tick  <= 1'b1;
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                ST_PAUSE: r_presc <= r_presc;
                default:  r_presc <= '0;
            endcase

            if (w_press_clear) begin
                r_state <= ST_IDLE;
                r_run   <= 1'b0;
                r_presc <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_press_start) begin
                            r_state <= ST_RUN;
                            r_run   <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (w_press_stop) begin
                            r_state <= ST_PAUSE;
                            r_run   <= 1'b0;
                        end
                    end
                    ST_PAUSE: begin
                        if (w_press_start) begin
                            r_state <= ST_RUN;
                            r_run   <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_run   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign run   = r_run;
    assign tick  = r_tick;
    assign clr   = r_clr;
    assign state = r_state;

    // Output invariants relied on by the digit chain.
    ap_run_matches_state: assert property (@(posedge clk) disable iff (reset)
        run == (state == ST_RUN));
    ap_state_legal: assert property (@(posedge clk) disable iff (reset)
        state != 2'b11);
    ap_tick_only_running: assert property (@(posedge clk) disable iff (reset)
        tick |-> (run || $past(run)));

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with short debounce (4) and tick divider (5).
module tb_stopwatch_ctrl;

    logic       clk;
    logic       reset;
    logic       btn_start;
    logic       btn_stop;
    logic       btn_clear;
    logic       run;
    logic       tick;
    logic       clr;
    logic [1:0] state;

    int n_total;
    int n_bad;

    stopwatch_ctrl #(.DEB_CYCLES(4), .TICK_DIV(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_stop  (btn_stop),
        .btn_clear (btn_clear),
        .run       (run),
        .tick      (tick),
        .clr       (clr),
        .state     (state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

    // One cycle: advance past the rising edge and settle before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected vector layout: {state[1:0], run, tick, clr}
    task automatic test_reset();
        logic [4:0] exp;
        reset     = 1'b1;
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        btn_clear = 1'b0;
        exp = 5'b00_000;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++;
            if ({state, run, tick, clr} !== exp) begin
                n_bad++;
                $display("FAIL reset_hold i=%0d got=%b exp=%b", i, {state, run, tick, clr}, exp);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_total++;
            if ({state, run, tick, clr} !== exp) begin
                n_bad++;
                $display("FAIL reset_idle i=%0d got=%b exp=%b", i, {state, run, tick, clr}, exp);
            end
        end
    endtask

    // Start held 10 cycles: RUN on cycle 7, then a tick every 5th cycle.
    task automatic test_start_run();
        logic [4:0] exp;
        int n_ticks;
        n_ticks = 0;
        btn_start = 1'b1;
        for (int k = 1; k <= 27; k++) begin
            step();
            if (k == 10) btn_start = 1'b0;
            if (k < 7) exp = 5'b00_000;
            else exp = {2'b01, 1'b1, (k > 7) && ((k - 7) % 5 == 0), 1'b0};
            if (k > 7 && tick === 1'b1) n_ticks++;
            n_total++;
            if ({state, run, tick, clr} !== exp) begin
                n_bad++;
                $display("FAIL start_run k=%0d got=%b exp=%b", k, {state, run, tick, clr}, exp);
            end
        end
        n_total++;
        if (n_ticks !== 4) begin
            n_bad++;
            $display("FAIL run_tick_count got=%0d exp=4", n_ticks);
        end
    endtask

    // Stop lands when the prescaler holds 2; resume must tick after 3 cycles.
    task automatic test_pause_resume();
        logic [4:0] exp;
        btn_stop = 1'b1;
        for (int j = 1; j <= 37; j++) begin
            step();
            if (j == 10) btn_stop = 1'b0;
            if (j < 7) exp = {2'b01, 1'b1, j == 5, 1'b0};
            else exp = 5'b10_000;
            n_total++;
            if ({state, run, tick, clr} !== exp) begin
                n_bad++;
                $display("FAIL pause j=%0d got=%b exp=%b", j, {state, run, tick, clr}, exp);
            end
        end
        btn_start = 1'b1;
        for (int m = 1; m <= 10; m++) begin
            step();
            if (m == 5) btn_start = 1'b0;
            if (m < 7) exp = 5'b10_000;
            else exp = {2'b01, 1'b1, m == 10, 1'b0};
            n_total++;
            if ({state, run, tick, clr} !== exp) begin
                n_bad++;
                $display("FAIL resume m=%0d got=%b exp=%b", m, {state, run, tick, clr}, exp);
            end
        end
    endtask

    // Clear in RUN: IDLE and clr together, then everything quiet.
    task automatic test_clear_run();
        logic [4:0] exp;
        btn_clear = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            step();
            if (c == 5) btn_clear = 1'b0;
            if (c < 7) exp = {2'b01, 1'b1, c == 5, 1'b0};
            else if (c == 7) exp = 5'b00_001;
            else exp = 5'b00_000;
            n_total++;
            if ({state, run, tick, clr} !== exp) begin
                n_bad++;
                $display("FAIL clear_run c=%0d got=%b exp=%b", c, {state, run, tick, clr}, exp);
            end
        end
    endtask

    // Short pulses and 2-cycle chatter must never be accepted.
    task automatic test_bounce();
        logic [4:0] exp;
        exp = 5'b00_000;
        btn_start = 1'b1;
        for (int b = 1; b <= 30; b++) begin
            step();
            if (b == 3) btn_start = 1'b0;
            else if (b >= 10 && b < 22) btn_start = ((b / 2) % 2 == 0);
            else if (b >= 22) btn_start = 1'b0;
            n_total++;
            if ({state, run, tick, clr} !== exp) begin
                n_bad++;
                $display("FAIL bounce b=%0d got=%b exp=%b", b, {state, run, tick, clr}, exp);
            end
        end
    endtask

    // Start and clear together in IDLE: clear wins, one clr pulse, stay IDLE.
    task automatic test_start_clear_idle();
        logic [4:0] exp;
        btn_start = 1'b1;
        btn_clear = 1'b1;
        for (int d = 1; d <= 20; d++) begin
            step();
            if (d == 6) begin
                btn_start = 1'b0;
                btn_clear = 1'b0;
            end
            exp = (d == 7) ? 5'b00_001 : 5'b00_000;
            n_total++;
            if ({state, run, tick, clr} !== exp) begin
                n_bad++;
                $display("FAIL start_clear d=%0d got=%b exp=%b", d, {state, run, tick, clr}, exp);
            end
        end
    endtask

    // Reset with the prescaler at 4 suppresses the pending tick; held start re-accepted.
    task automatic test_reset_mid_run();
        logic [4:0] exp;
        btn_start = 1'b1;
        for (int r = 1; r <= 30; r++) begin
            step();
            if (r == 11) reset = 1'b1;
            if (r == 13) reset = 1'b0;
            if (r == 26) btn_start = 1'b0;
            if (r < 7) exp = 5'b00_000;
            else if (r <= 11) exp = 5'b01_100;
            else if (r < 20) exp = 5'b00_000;
            else exp = {2'b01, 1'b1, (r == 25) || (r == 30), 1'b0};
            n_total++;
            if ({state, run, tick, clr} !== exp) begin
                n_bad++;
                $display("FAIL reset_mid_run r=%0d got=%b exp=%b", r, {state, run, tick, clr}, exp);
            end
        end
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        reset     = 1'b1;
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        btn_clear = 1'b0;
        test_reset();
        test_start_run();
        test_pause_resume();
        test_clear_run();
        test_bounce();
        test_start_clear_idle();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
